// File: rtl/codec_tx_serializer.sv
// Float-pair to Q1.23 PCM converter with one-deep holding register and I2S-style serializer.
// Holding register accepts a pair whenever empty; the frame load at slot 0 drains it, or sends zeros on underrun.
module codec_tx_serializer #(
  parameter int BCLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] float_l,
  input  logic [23:0] float_r,
  output logic        bclk,
  output logic        lrclk,
  output logic        sdata,
  output logic        sat,
  output logic        underrun
);

  localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  // Returns {saturated, pcm}; truncation toward zero falls out of shifting the magnitude.
  function automatic logic [24:0] to_pcm(input logic [23:0] f);
    logic [6:0]  e;
    logic [23:0] m;
    logic [23:0] mag;
    logic [24:0] res;
    e   = f[22:16];
    m   = {7'd0, 1'b1, f[15:0]};
    mag = '0;
    res = '0;
    if (e == 7'd0) begin
      res = '0;
    end else if (e >= 7'd63) begin
      res = {1'b1, (f[23] ? 24'h800000 : 24'h7FFFFF)};
    end else begin
      if (e >= 7'd56) mag = m << (e - 7'd56);
      else            mag = m >> (7'd56 - e);
      res = {1'b0, (f[23] ? (~mag + 24'd1) : mag)};
    end
    return res;
  endfunction

  logic [DW-1:0] div_q, div_d;
  logic          bclk_q, bclk_d;
  logic [5:0]    slot_q, slot_d;
  logic          lrclk_q, lrclk_d;
  logic          sdata_q, sdata_d;
  logic          full_q, full_d;
  logic [23:0]   hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic [23:0]   sh_l_q, sh_l_d, sh_r_q, sh_r_d;
  logic          sat_q, sat_d;
  logic          underrun_q, underrun_d;

  logic          tick, fall, load, accept;
  logic [5:0]    slot_nxt;
  logic [24:0]   conv_l, conv_r;

  assign tick     = (div_q == DW'(BCLK_DIV - 1));
  assign fall     = tick & bclk_q;
  assign load     = fall & (slot_q == 6'd63);
  assign accept   = in_valid & ~full_q;
  assign slot_nxt = slot_q + 6'd1;
  assign conv_l   = to_pcm(float_l);
  assign conv_r   = to_pcm(float_r);

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_q      <= '0;
      bclk_q     <= 1'b0;
      slot_q     <= 6'd63;
      lrclk_q    <= 1'b1;
      sdata_q    <= 1'b0;
      full_q     <= 1'b0;
      hold_l_q   <= '0;
      hold_r_q   <= '0;
      sh_l_q     <= '0;
      sh_r_q     <= '0;
      sat_q      <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      div_q      <= div_d;
      bclk_q     <= bclk_d;
      slot_q     <= slot_d;
      lrclk_q    <= lrclk_d;
      sdata_q    <= sdata_d;
      full_q     <= full_d;
      hold_l_q   <= hold_l_d;
      hold_r_q   <= hold_r_d;
      sh_l_q     <= sh_l_d;
      sh_r_q     <= sh_r_d;
      sat_q      <= sat_d;
      underrun_q <= underrun_d;
    end
  end

  always_comb begin
    div_d      = tick ? '0 : div_q + DW'(1);
    bclk_d     = tick ? ~bclk_q : bclk_q;
    slot_d     = slot_q;
    lrclk_d    = lrclk_q;
    sdata_d    = sdata_q;
    sh_l_d     = sh_l_q;
    sh_r_d     = sh_r_q;
    hold_l_d   = hold_l_q;
    hold_r_d   = hold_r_q;
    if (fall) begin
      slot_d  = slot_nxt;
      lrclk_d = slot_nxt[5];
      sdata_d = 1'b0;
      if (load) begin
        sh_l_d = full_q ? hold_l_q : '0;
        sh_r_d = full_q ? hold_r_q : '0;
      end else if (slot_nxt >= 6'd1 && slot_nxt <= 6'd24) begin
        sdata_d = sh_l_q[23];
        sh_l_d  = {sh_l_q[22:0], 1'b0};
      end else if (slot_nxt >= 6'd33 && slot_nxt <= 6'd56) begin
        sdata_d = sh_r_q[23];
        sh_r_d  = {sh_r_q[22:0], 1'b0};
      end
    end
    // The load sees the pre-cycle full flag, so a same-cycle accept lands in the next frame.
    if (accept) begin
      hold_l_d = conv_l[23:0];
      hold_r_d = conv_r[23:0];
      full_d   = 1'b1;
    end else if (load) begin
      full_d   = 1'b0;
    end else begin
      full_d   = full_q;
    end
    sat_d      = accept & (conv_l[24] | conv_r[24]);
    underrun_d = load & ~full_q;
  end

  assign in_ready = ~full_q;
  assign bclk     = bclk_q;
  assign lrclk    = lrclk_q;
  assign sdata    = sdata_q;
  assign sat      = sat_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_codec_tx_serializer.sv
// Directed bench for codec_tx_serializer: conversion, saturation, underrun, backpressure and reset cases.
module tb_codec_tx_serializer;
  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, bclk, lrclk, sdata, sat, underrun;
  logic [23:0] float_l, float_r;
  int          n_vec = 0;
  int          n_err = 0;

  logic [63:0] fd, flr;
  logic [63:0] lr_exp;
  int          fur, fst, fgl;

  always #5 clk = ~clk;

  codec_tx_serializer #(.BCLK_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .float_l(float_l), .float_r(float_r), .bclk(bclk), .lrclk(lrclk),
    .sdata(sdata), .sat(sat), .underrun(underrun)
  );

  function automatic logic [23:0] word_l(input logic [63:0] d);
    logic [23:0] w;
    for (int i = 0; i < 24; i++) w[23-i] = d[1+i];
    return w;
  endfunction

  function automatic logic [23:0] word_r(input logic [63:0] d);
    logic [23:0] w;
    for (int i = 0; i < 24; i++) w[23-i] = d[33+i];
    return w;
  endfunction

  function automatic logic [63:0] other_bits(input logic [63:0] d);
    logic [63:0] m;
    m = d;
    for (int i = 1; i <= 24; i++) m[i] = 1'b0;
    for (int i = 33; i <= 56; i++) m[i] = 1'b0;
    return m;
  endfunction

  // Records one full frame starting at the cycle right after its load edge.
  task automatic capture(output logic [63:0] d, output logic [63:0] lr, output int ur, output int st, output int gl);
    logic pb, ps, pl;
    d = '0; lr = '0; ur = 0; st = 0; gl = 0;
    pb = bclk; ps = sdata; pl = lrclk;
    for (int c = 0; c < 128*DIV; c++) begin
      if (c > 0) @(negedge clk);
      if (c % (2*DIV) == DIV) begin
        d[c/(2*DIV)]  = sdata;
        lr[c/(2*DIV)] = lrclk;
      end
      if (c > 0 && (sdata !== ps || lrclk !== pl) && !(pb && !bclk)) gl++;
      if (underrun) ur++;
      if (sat) st++;
      pb = bclk; ps = sdata; pl = lrclk;
    end
  endtask

  task automatic wait_load();
    logic pb, pl;
    bit   found;
    found = 0;
    pb = bclk; pl = lrclk;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (pb && !bclk && pl && !lrclk) begin
        found = 1;
        break;
      end
      pb = bclk; pl = lrclk;
    end
    n_vec++; if (!found) begin n_err++; $display("FAIL wait_load: no frame load seen within 2000 cycles, required one"); end
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; float_l = '0; float_r = '0;
    repeat (3) @(negedge clk);
    n_vec++; if (bclk !== 1'b0) begin n_err++; $display("FAIL rst_bclk got=%b exp=0", bclk); end
    n_vec++; if (lrclk !== 1'b1) begin n_err++; $display("FAIL rst_lrclk got=%b exp=1", lrclk); end
    n_vec++; if (sdata !== 1'b0) begin n_err++; $display("FAIL rst_sdata got=%b exp=0", sdata); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    n_vec++; if (sat !== 1'b0) begin n_err++; $display("FAIL rst_sat got=%b exp=0", sat); end
    n_vec++; if (underrun !== 1'b0) begin n_err++; $display("FAIL rst_underrun got=%b exp=0", underrun); end
    rst = 1'b1;
    for (int k = 1; k <= 2*DIV; k++) begin
      @(negedge clk);
      if (k == DIV-1) begin n_vec++; if (bclk !== 1'b0) begin n_err++; $display("FAIL first_rise_early got=%b exp=0", bclk); end end
      if (k == DIV) begin n_vec++; if (bclk !== 1'b1) begin n_err++; $display("FAIL first_rise got=%b exp=1", bclk); end end
    end
    n_vec++; if (bclk !== 1'b0) begin n_err++; $display("FAIL first_fall got=%b exp=0", bclk); end
    n_vec++; if (lrclk !== 1'b0) begin n_err++; $display("FAIL first_load_lrclk got=%b exp=0", lrclk); end
    n_vec++; if (underrun !== 1'b1) begin n_err++; $display("FAIL first_load_underrun got=%b exp=1", underrun); end
  endtask

  task automatic test_conversion();
    in_valid = 1'b1; float_l = 24'h3E0000; float_r = 24'hBE8000;
    @(negedge clk);
    in_valid = 1'b0;
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL conv_accept_ready got=%b exp=0", in_ready); end
    n_vec++; if (sat !== 1'b0) begin n_err++; $display("FAIL conv_sat got=%b exp=0", sat); end
    wait_load();
    n_vec++; if (underrun !== 1'b0) begin n_err++; $display("FAIL conv_underrun got=%b exp=0", underrun); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL conv_ready_return got=%b exp=1", in_ready); end
    capture(fd, flr, fur, fst, fgl);
    n_vec++; if (word_l(fd) !== 24'h400000) begin n_err++; $display("FAIL conv_L got=%h exp=400000", word_l(fd)); end
    n_vec++; if (word_r(fd) !== 24'hA00000) begin n_err++; $display("FAIL conv_R got=%h exp=a00000", word_r(fd)); end
    n_vec++; if (other_bits(fd) !== 64'd0) begin n_err++; $display("FAIL conv_idle_slots got=%h exp=0", other_bits(fd)); end
    n_vec++; if (flr !== lr_exp) begin n_err++; $display("FAIL conv_lrclk got=%h exp=%h", flr, lr_exp); end
    n_vec++; if (fgl !== 0) begin n_err++; $display("FAIL conv_change_off_fall got=%0d exp=0", fgl); end
    n_vec++; if (fst !== 0) begin n_err++; $display("FAIL conv_sat_frame got=%0d exp=0", fst); end
  endtask

  task automatic test_saturation();
    wait_load();
    in_valid = 1'b1; float_l = 24'h3F0000; float_r = 24'hBF0000;
    @(negedge clk);
    in_valid = 1'b0;
    n_vec++; if (sat !== 1'b1) begin n_err++; $display("FAIL sat_pulse got=%b exp=1", sat); end
    @(negedge clk);
    n_vec++; if (sat !== 1'b0) begin n_err++; $display("FAIL sat_one_cycle got=%b exp=0", sat); end
    wait_load();
    capture(fd, flr, fur, fst, fgl);
    n_vec++; if (word_l(fd) !== 24'h7FFFFF) begin n_err++; $display("FAIL sat_L got=%h exp=7fffff", word_l(fd)); end
    n_vec++; if (word_r(fd) !== 24'h800000) begin n_err++; $display("FAIL sat_R got=%h exp=800000", word_r(fd)); end
    wait_load();
    in_valid = 1'b1; float_l = 24'h1E0000; float_r = 24'h000000;
    @(negedge clk);
    in_valid = 1'b0;
    n_vec++; if (sat !== 1'b0) begin n_err++; $display("FAIL flush_sat got=%b exp=0", sat); end
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL flush_ready got=%b exp=0", in_ready); end
    wait_load();
    n_vec++; if (underrun !== 1'b0) begin n_err++; $display("FAIL flush_underrun got=%b exp=0", underrun); end
    capture(fd, flr, fur, fst, fgl);
    n_vec++; if (fd !== 64'd0) begin n_err++; $display("FAIL flush_frame got=%h exp=0", fd); end
  endtask

  task automatic test_underrun();
    in_valid = 1'b0;
    wait_load();
    for (int f = 0; f < 3; f++) begin
      n_vec++; if (underrun !== 1'b1) begin n_err++; $display("FAIL ur_at_load frame=%0d got=%b exp=1", f, underrun); end
      capture(fd, flr, fur, fst, fgl);
      n_vec++; if (fd !== 64'd0) begin n_err++; $display("FAIL ur_sdata frame=%0d got=%h exp=0", f, fd); end
      n_vec++; if (fur !== 1) begin n_err++; $display("FAIL ur_count frame=%0d got=%0d exp=1", f, fur); end
      n_vec++; if (flr !== lr_exp) begin n_err++; $display("FAIL ur_lrclk frame=%0d got=%h exp=%h", f, flr, lr_exp); end
      if (f < 2) @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic pb, pl;
    bit   found;
    int   early;
    wait_load();
    in_valid = 1'b1; float_l = 24'h3C0000; float_r = 24'h3D4000;
    @(negedge clk);
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_first_accept got=%b exp=0", in_ready); end
    float_l = 24'hB70000; float_r = 24'h38FFFF;
    found = 0; early = 0; pb = bclk; pl = lrclk;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (pb && !bclk && pl && !lrclk) begin found = 1; break; end
      if (in_ready) early++;
      pb = bclk; pl = lrclk;
    end
    n_vec++; if (!found) begin n_err++; $display("FAIL b2b_load_seen got=0 exp=1"); end
    n_vec++; if (early !== 0) begin n_err++; $display("FAIL b2b_ready_early got=%0d exp=0", early); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_after_load got=%b exp=1", in_ready); end
    n_vec++; if (underrun !== 1'b0) begin n_err++; $display("FAIL b2b_underrun1 got=%b exp=0", underrun); end
    fork
      capture(fd, flr, fur, fst, fgl);
      begin
        @(negedge clk);
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_second_accept got=%b exp=0", in_ready); end
        in_valid = 1'b0;
      end
    join
    n_vec++; if (word_l(fd) !== 24'h100000) begin n_err++; $display("FAIL b2b_P1_L got=%h exp=100000", word_l(fd)); end
    n_vec++; if (word_r(fd) !== 24'h280000) begin n_err++; $display("FAIL b2b_P1_R got=%h exp=280000", word_r(fd)); end
    @(negedge clk);
    n_vec++; if (underrun !== 1'b0) begin n_err++; $display("FAIL b2b_underrun2 got=%b exp=0", underrun); end
    capture(fd, flr, fur, fst, fgl);
    n_vec++; if (word_l(fd) !== 24'hFF8000) begin n_err++; $display("FAIL b2b_P2_L got=%h exp=ff8000", word_l(fd)); end
    n_vec++; if (word_r(fd) !== 24'h01FFFF) begin n_err++; $display("FAIL b2b_P2_R got=%h exp=01ffff", word_r(fd)); end
  endtask

  task automatic test_simultaneous();
    in_valid = 1'b1; float_l = 24'h2F0000; float_r = 24'h80ABCD;
    @(negedge clk);
    in_valid = 1'b0;
    n_vec++; if ({bclk, lrclk} !== 2'b00) begin n_err++; $display("FAIL sim_load_edge got=%b exp=00", {bclk, lrclk}); end
    n_vec++; if (underrun !== 1'b1) begin n_err++; $display("FAIL sim_underrun got=%b exp=1", underrun); end
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL sim_held got=%b exp=0", in_ready); end
    n_vec++; if (sat !== 1'b0) begin n_err++; $display("FAIL sim_sat got=%b exp=0", sat); end
    capture(fd, flr, fur, fst, fgl);
    n_vec++; if (fd !== 64'd0) begin n_err++; $display("FAIL sim_zero_frame got=%h exp=0", fd); end
    @(negedge clk);
    n_vec++; if (underrun !== 1'b0) begin n_err++; $display("FAIL sim_next_underrun got=%b exp=0", underrun); end
    capture(fd, flr, fur, fst, fgl);
    n_vec++; if (word_l(fd) !== 24'h000080) begin n_err++; $display("FAIL sim_L got=%h exp=000080", word_l(fd)); end
    n_vec++; if (word_r(fd) !== 24'h000000) begin n_err++; $display("FAIL sim_R_negzero got=%h exp=000000", word_r(fd)); end
  endtask

  task automatic test_midframe_reset();
    @(negedge clk);
    n_vec++; if (underrun !== 1'b1) begin n_err++; $display("FAIL mr_pre_underrun got=%b exp=1", underrun); end
    in_valid = 1'b1; float_l = 24'h390000; float_r = 24'hBA0001;
    @(negedge clk);
    in_valid = 1'b0;
    wait_load();
    n_vec++; if (underrun !== 1'b0) begin n_err++; $display("FAIL mr_loaded got=%b exp=0", underrun); end
    repeat (40*2*DIV + 1) @(negedge clk);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL mr_held_before_rst got=%b exp=0", in_ready); end
    n_vec++; if (lrclk !== 1'b1) begin n_err++; $display("FAIL mr_slot40_lrclk got=%b exp=1", lrclk); end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    n_vec++; if ({bclk, lrclk, sdata, in_ready, sat, underrun} !== 6'b010100) begin n_err++; $display("FAIL mr_reset_outputs got=%b exp=010100", {bclk, lrclk, sdata, in_ready, sat, underrun}); end
    for (int k = 1; k <= 2*DIV; k++) begin
      @(negedge clk);
      if (k == 2*DIV-1) begin n_vec++; if ({bclk, underrun} !== 2'b10) begin n_err++; $display("FAIL mr_before_fall got=%b exp=10", {bclk, underrun}); end end
    end
    n_vec++; if ({bclk, lrclk, underrun} !== 3'b001) begin n_err++; $display("FAIL mr_restart_load got=%b exp=001", {bclk, lrclk, underrun}); end
    capture(fd, flr, fur, fst, fgl);
    n_vec++; if (fd !== 64'd0) begin n_err++; $display("FAIL mr_pair_discarded got=%h exp=0", fd); end
  endtask

  initial begin
    lr_exp = 64'hFFFFFFFF_00000000;
    test_reset();
    test_conversion();
    test_saturation();
    test_underrun();
    test_back_to_back();
    test_simultaneous();
    test_midframe_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
